// File: rtl/mem_ctrl_if.sv
// LSB <-> memory controller request/response bundle.
// The LSB drives a request and holds it until the one-cycle done pulse comes back.
interface mem_ctrl_if;
   logic        lsb_req;
   logic        lsb_we;
   logic [31:0] lsb_addr;
   logic [2:0]  lsb_size;
   logic        lsb_signed;
   logic [31:0] lsb_wdata;
   logic        lsb_done;
   logic [31:0] lsb_rdata;

   // Requester side (LSB)
   modport master (
      output lsb_req, lsb_we, lsb_addr, lsb_size, lsb_signed, lsb_wdata,
      input  lsb_done, lsb_rdata
   );

   // Responder side (memory controller)
   modport slave (
      input  lsb_req, lsb_we, lsb_addr, lsb_size, lsb_signed, lsb_wdata,
      output lsb_done, lsb_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: owns the single-byte RAM/IO port. Streams one instruction byte per cycle
// to fetch while idle, and runs 1/2/4-byte LSB loads/stores, which have priority and run to
// completion once started (loads can be aborted by flush).
module mem_ctrl #(
   parameter logic [1:0] IO_BASE_BITS = 2'b11
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        rdy_in,
   input  logic        flush,
   // fetch side
   input  logic [31:0] req_addr,
   output logic        mem_rdy,
   output logic [7:0]  mem_byte,
   // LSB side
   mem_ctrl_if.slave   lsb_bus,
   output logic        IO_is_writing,
   input  logic        io_buffer_full,
   // RAM/IO port
   input  logic [7:0]  ram_din,
   output logic [31:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_wr
);

   typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] lsb_rdata_q, lsb_rdata_d;

   logic        accept;
   logic        is_io;
   logic        io_stall;
   logic [2:0]  size_eff;
   logic [31:0] cur_addr;
   logic [31:0] prev_addr;
   logic [31:0] load_word;
   logic [31:0] load_ext;
   logic [31:0] wshift;

   assign mem_byte           = ram_din;
   assign lsb_bus.lsb_done   = lsb_done_q;
   assign lsb_bus.lsb_rdata  = lsb_rdata_q;

   // Request acceptance and address helpers
   always_comb begin
      accept    = (state_q == StIdle) && lsb_bus.lsb_req && !lsb_done_q &&
                  !(flush && !lsb_bus.lsb_we);
      is_io     = (addr_q[17:16] == IO_BASE_BITS);
      io_stall  = is_io && io_buffer_full;
      cur_addr  = addr_q + {29'd0, cnt_q};
      prev_addr = cur_addr - 32'd1;
      wshift    = wdata_q >> {cnt_q[1:0], 3'b000};
      case (lsb_bus.lsb_size)
         3'd1:    size_eff = 3'd1;
         3'd2:    size_eff = 3'd2;
         default: size_eff = 3'd4;
      endcase
   end

   // Merge the byte arriving this cycle (byte cnt-1) into the load buffer, then extend
   always_comb begin
      load_word = rbuf_q;
      case (cnt_q)
         3'd1:    load_word[7:0]   = ram_din;
         3'd2:    load_word[15:8]  = ram_din;
         3'd3:    load_word[23:16] = ram_din;
         3'd4:    load_word[31:24] = ram_din;
         default: ;
      endcase
      case (size_q)
         3'd1:    load_ext = {{24{signed_q & load_word[7]}}, load_word[7:0]};
         3'd2:    load_ext = {{16{signed_q & load_word[15]}}, load_word[15:0]};
         default: load_ext = load_word;
      endcase
   end

   // Next-state logic for the transaction FSM
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      lsb_done_d  = 1'b0;
      lsb_rdata_d = lsb_rdata_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d   = lsb_bus.lsb_addr;
               size_d   = size_eff;
               signed_d = lsb_bus.lsb_signed;
               wdata_d  = lsb_bus.lsb_wdata;
               rbuf_d   = 32'd0;
               cnt_d    = 3'd0;
               state_d  = lsb_bus.lsb_we ? StStore : StLoad;
            end
         end
         StLoad: begin
            if (flush) begin
               cnt_d   = 3'd0;
               state_d = StIdle;
            end else begin
               rbuf_d = load_word;
               if (cnt_q == size_q) begin
                  lsb_rdata_d = load_ext;
                  lsb_done_d  = 1'b1;
                  cnt_d       = 3'd0;
                  state_d     = StIdle;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         StStore: begin
            if (!io_stall) begin
               if (cnt_q == size_q - 3'd1) begin
                  lsb_done_d = 1'b1;
                  cnt_d      = 3'd0;
                  state_d    = StIdle;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; rdy_in low freezes everything
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         addr_q      <= 32'd0;
         size_q      <= 3'd0;
         signed_q    <= 1'b0;
         wdata_q     <= 32'd0;
         rbuf_q      <= 32'd0;
         lsb_done_q  <= 1'b0;
         lsb_rdata_q <= 32'd0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         wdata_q     <= wdata_d;
         rbuf_q      <= rbuf_d;
         lsb_done_q  <= lsb_done_d;
         lsb_rdata_q <= lsb_rdata_q == lsb_rdata_d ? lsb_rdata_q : lsb_rdata_d;
      end
   end

   // RAM port drive. Fetch addresses pass straight through so the byte lands next cycle.
   // Outputs are forced to their idle values while reset is asserted.
   always_comb begin
      mem_rdy       = 1'b0;
      ram_a         = 32'd0;
      ram_dout      = 8'd0;
      ram_wr        = 1'b0;
      IO_is_writing = (state_q == StStore) && is_io;
      if (rst_in_n) begin
         case (state_q)
            StIdle: begin
               if (!accept) begin
                  mem_rdy = rdy_in;
                  ram_a   = req_addr;
               end
            end
            StLoad: begin
               // While frozen, re-read the byte still owed so ram_din is correct on resume
               ram_a = (!rdy_in && cnt_q != 3'd0) ? prev_addr : cur_addr;
            end
            StStore: begin
               ram_a    = cur_addr;
               ram_dout = wshift[7:0];
               ram_wr   = rdy_in && !io_stall;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch stream, loads/stores of each size, IO stall,
// rdy freeze, flush and async reset.
module tb_mem_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in_n;
   logic        rdy_in;
   logic        flush;
   logic [31:0] req_addr;
   logic        mem_rdy;
   logic [7:0]  mem_byte;
   logic        IO_is_writing;
   logic        io_buffer_full;
   logic [7:0]  ram_din;
   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_wr;

   mem_ctrl_if lsb_bus ();

   mem_ctrl #(.IO_BASE_BITS(2'b11)) dut (
      .clk_in        (clk_in),
      .rst_in_n      (rst_in_n),
      .rdy_in        (rdy_in),
      .flush         (flush),
      .req_addr      (req_addr),
      .mem_rdy       (mem_rdy),
      .mem_byte      (mem_byte),
      .lsb_bus       (lsb_bus),
      .IO_is_writing (IO_is_writing),
      .io_buffer_full(io_buffer_full),
      .ram_din       (ram_din),
      .ram_a         (ram_a),
      .ram_dout      (ram_dout),
      .ram_wr        (ram_wr)
   );

   always #5 clk_in = ~clk_in;

   // 4 KiB RAM model with one-cycle read latency; every write is logged
   logic [7:0]  mem [0:4095];
   logic [31:0] wr_a[$];
   logic [7:0]  wr_d[$];
   always @(posedge clk_in) begin
      if (ram_wr) begin
         mem[ram_a[11:0]] <= ram_dout;
         wr_a.push_back(ram_a);
         wr_d.push_back(ram_dout);
      end
      ram_din <= mem[ram_a[11:0]];
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Issue one LSB transaction starting this cycle (cycle 0). Returns the cycle of lsb_done
   // (-1 on timeout), the read data, and how many cycles fetch was granted meanwhile.
   task automatic lsb_txn(input logic we, input logic [31:0] addr, input logic [2:0] size,
                          input logic sgn, input logic [31:0] wdata, input int stall_at,
                          output int lat, output logic [31:0] rdata, output int rdy_hits);
      lsb_bus.lsb_req    = 1'b1;
      lsb_bus.lsb_we     = we;
      lsb_bus.lsb_addr   = addr;
      lsb_bus.lsb_size   = size;
      lsb_bus.lsb_signed = sgn;
      lsb_bus.lsb_wdata  = wdata;
      lat      = -1;
      rdata    = 32'd0;
      rdy_hits = 0;
      for (int c = 0; c < 24 && lat < 0; c++) begin
         rdy_in = !(stall_at >= 0 && c >= stall_at && c < stall_at + 2);
         @(negedge clk_in);
         if (lsb_bus.lsb_done) begin
            lat   = c;
            rdata = lsb_bus.lsb_rdata;
         end else if (mem_rdy) begin
            rdy_hits++;
         end
         step();
      end
      rdy_in          = 1'b1;
      lsb_bus.lsb_req = 1'b0;
   endtask

   int          lat;
   int          hits;
   int          dones;
   logic [31:0] rd;

   initial begin
      rst_in_n           = 1'b0;
      rdy_in             = 1'b1;
      flush              = 1'b0;
      req_addr           = 32'h0;
      io_buffer_full     = 1'b0;
      lsb_bus.lsb_req    = 1'b0;
      lsb_bus.lsb_we     = 1'b0;
      lsb_bus.lsb_addr   = 32'h0;
      lsb_bus.lsb_size   = 3'd1;
      lsb_bus.lsb_signed = 1'b0;
      lsb_bus.lsb_wdata  = 32'h0;
      mem[12'h100] <= 8'h11;
      mem[12'h101] <= 8'h22;
      mem[12'h200] <= 8'h80;
      mem[12'h201] <= 8'h00;
      mem[12'h202] <= 8'h00;
      mem[12'h203] <= 8'h00;
      mem[12'h300] <= 8'hF0;
      mem[12'h302] <= 8'h34;
      mem[12'h303] <= 8'h92;
      mem[12'hFFF] <= 8'h5A;
      mem[12'h000] <= 8'hC3;

      // Reset values
      #12;
      check("rst_mem_rdy", {31'd0, mem_rdy}, 32'd0);
      check("rst_ram_a", ram_a, 32'd0);
      check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      check("rst_done", {31'd0, lsb_bus.lsb_done}, 32'd0);
      check("rst_rdata", lsb_bus.lsb_rdata, 32'd0);
      check("rst_io", {31'd0, IO_is_writing}, 32'd0);
      @(negedge clk_in);
      rst_in_n = 1'b1;
      step();

      // Fetch stream
      req_addr = 32'h100;
      @(negedge clk_in);
      check("if_rdy0", {31'd0, mem_rdy}, 32'd1);
      check("if_a0", ram_a, 32'h100);
      step();
      req_addr = 32'h101;
      @(negedge clk_in);
      check("if_rdy1", {31'd0, mem_rdy}, 32'd1);
      check("if_byte0", {24'd0, mem_byte}, 32'h11);
      step();
      @(negedge clk_in);
      check("if_byte1", {24'd0, mem_byte}, 32'h22);
      step();

      // Loads
      lsb_txn(1'b0, 32'h200, 3'd4, 1'b1, 32'h0, -1, lat, rd, hits);
      check("lw_lat", lat, 6);
      check("lw_data", rd, 32'h0000_0080);
      check("lw_rdy", hits, 0);
      lsb_txn(1'b0, 32'h300, 3'd1, 1'b1, 32'h0, -1, lat, rd, hits);
      check("lb_lat", lat, 3);
      check("lb_data", rd, 32'hFFFF_FFF0);
      lsb_txn(1'b0, 32'h300, 3'd1, 1'b0, 32'h0, -1, lat, rd, hits);
      check("lbu_data", rd, 32'h0000_00F0);
      lsb_txn(1'b0, 32'h302, 3'd2, 1'b1, 32'h0, -1, lat, rd, hits);
      check("lh_lat", lat, 4);
      check("lh_data", rd, 32'hFFFF_9234);
      lsb_txn(1'b0, 32'h200, 3'd3, 1'b0, 32'h0, -1, lat, rd, hits);
      check("sz3_lat", lat, 6);
      check("sz3_data", rd, 32'h0000_0080);
      lsb_txn(1'b0, 32'hFFFF_FFFF, 3'd2, 1'b0, 32'h0, -1, lat, rd, hits);
      check("wrap_data", rd, 32'h0000_C35A);

      // Halfword store, then read it back
      wr_a.delete();
      wr_d.delete();
      lsb_txn(1'b1, 32'h400, 3'd2, 1'b0, 32'h0000_BEEF, -1, lat, rd, hits);
      check("sh_lat", lat, 3);
      check("sh_nwr", wr_a.size(), 2);
      if (wr_a.size() == 2) begin
         check("sh_a0", wr_a[0], 32'h400);
         check("sh_d0", {24'd0, wr_d[0]}, 32'hEF);
         check("sh_a1", wr_a[1], 32'h401);
         check("sh_d1", {24'd0, wr_d[1]}, 32'hBE);
      end
      lsb_txn(1'b0, 32'h400, 3'd2, 1'b0, 32'h0, -1, lat, rd, hits);
      check("sh_rb", rd, 32'h0000_BEEF);

      // IO store stalled by a full buffer for cycles 1-3
      wr_a.delete();
      wr_d.delete();
      lsb_bus.lsb_req   = 1'b1;
      lsb_bus.lsb_we    = 1'b1;
      lsb_bus.lsb_addr  = 32'h0003_0000;
      lsb_bus.lsb_size  = 3'd1;
      lsb_bus.lsb_wdata = 32'h41;
      io_buffer_full    = 1'b1;
      @(negedge clk_in);
      check("io_c0_rdy", {31'd0, mem_rdy}, 32'd0);
      step();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_in);
         check("io_stall_io", {31'd0, IO_is_writing}, 32'd1);
         check("io_stall_wr", {31'd0, ram_wr}, 32'd0);
         step();
      end
      io_buffer_full = 1'b0;
      @(negedge clk_in);
      check("io_c4_io", {31'd0, IO_is_writing}, 32'd1);
      check("io_c4_wr", {31'd0, ram_wr}, 32'd1);
      check("io_c4_a", ram_a, 32'h0003_0000);
      check("io_c4_d", {24'd0, ram_dout}, 32'h41);
      step();
      @(negedge clk_in);
      check("io_c5_done", {31'd0, lsb_bus.lsb_done}, 32'd1);
      check("io_c5_io", {31'd0, IO_is_writing}, 32'd0);
      step();
      lsb_bus.lsb_req = 1'b0;
      check("io_nwr", wr_a.size(), 1);

      // rdy_in low for cycles 2-3 of a word load: result unchanged, two cycles later
      lsb_txn(1'b0, 32'h200, 3'd4, 1'b1, 32'h0, 2, lat, rd, hits);
      check("frz_lat", lat, 8);
      check("frz_data", rd, 32'h0000_0080);

      // Flush at cycle 3 of a word load
      lsb_bus.lsb_req  = 1'b1;
      lsb_bus.lsb_we   = 1'b0;
      lsb_bus.lsb_addr = 32'h200;
      lsb_bus.lsb_size = 3'd4;
      step();
      step();
      step();
      flush           = 1'b1;
      lsb_bus.lsb_req = 1'b0;
      @(negedge clk_in);
      check("fl_c3_rdy", {31'd0, mem_rdy}, 32'd0);
      step();
      flush    = 1'b0;
      req_addr = 32'h104;
      @(negedge clk_in);
      check("fl_c4_rdy", {31'd0, mem_rdy}, 32'd1);
      check("fl_c4_a", ram_a, 32'h104);
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in);
         if (lsb_bus.lsb_done) dones++;
         step();
      end
      check("fl_no_done", dones, 0);

      // Flush in idle blocks a load request
      lsb_bus.lsb_req = 1'b1;
      flush           = 1'b1;
      @(negedge clk_in);
      check("fli_rdy0", {31'd0, mem_rdy}, 32'd1);
      step();
      lsb_bus.lsb_req = 1'b0;
      flush           = 1'b0;
      @(negedge clk_in);
      check("fli_rdy1", {31'd0, mem_rdy}, 32'd1);
      step();

      // Async reset in the middle of an IO word store
      lsb_bus.lsb_req   = 1'b1;
      lsb_bus.lsb_we    = 1'b1;
      lsb_bus.lsb_addr  = 32'h0003_0004;
      lsb_bus.lsb_size  = 3'd4;
      lsb_bus.lsb_wdata = 32'h1234_5678;
      step();
      step();
      #2;
      check("ar_pre_wr", {31'd0, ram_wr}, 32'd1);
      check("ar_pre_io", {31'd0, IO_is_writing}, 32'd1);
      rst_in_n = 1'b0;
      #1;
      check("ar_wr", {31'd0, ram_wr}, 32'd0);
      check("ar_io", {31'd0, IO_is_writing}, 32'd0);
      check("ar_rdy", {31'd0, mem_rdy}, 32'd0);
      check("ar_a", ram_a, 32'd0);
      check("ar_dout", {24'd0, ram_dout}, 32'd0);
      check("ar_rdata", lsb_bus.lsb_rdata, 32'd0);
      check("ar_done", {31'd0, lsb_bus.lsb_done}, 32'd0);
      lsb_bus.lsb_req = 1'b0;
      @(negedge clk_in);
      rst_in_n = 1'b1;
      step();
      @(negedge clk_in);
      check("ar_post_rdy", {31'd0, mem_rdy}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
